// File: rtl/pi_sequencer_if.sv
// pi_sequencer_if
//  Bundles everything between the PI sequencer and the outside world: the update
//  handshake (go/busy/done), the error and speed inputs, the shared-ALU control and
//  operand bus, and the motor command outputs.
//  Modports:
//   master - the sequencer: drives ALU selects/flags, operand registers, lft/rht,
//            busy/done; receives go, err_in, Fwd and the ALU result dst.
//   slave  - the environment (error source, ALU, motor drivers): the mirror image.
//  Fwd is only routed through to the ALU; the sequencer never registers it.
interface pi_sequencer_if;
    logic        go;
    logic [11:0] err_in;
    logic [11:0] Fwd;
    logic [15:0] dst;
    logic [2:0]  src1sel;
    logic [2:0]  src0sel;
    logic        multiply;
    logic        mult2;
    logic        mult4;
    logic        sub;
    logic        saturate;
    logic [11:0] Error;
    logic [11:0] Intgrl;
    logic [11:0] Icomp;
    logic [15:0] Pcomp;
    logic [15:0] Accum;
    logic [11:0] lft;
    logic [11:0] rht;
    logic        busy;
    logic        done;

    modport master (
        input  go, err_in, Fwd, dst,
        output src1sel, src0sel, multiply, mult2, mult4, sub, saturate,
        output Error, Intgrl, Icomp, Pcomp, Accum,
        output lft, rht, busy, done
    );

    modport slave (
        output go, err_in, Fwd, dst,
        input  src1sel, src0sel, multiply, mult2, mult4, sub, saturate,
        input  Error, Intgrl, Icomp, Pcomp, Accum,
        input  lft, rht, busy, done
    );
endinterface

// File: rtl/pi_sequencer.sv
// pi_sequencer
//  Walks the shared ALU through one PI motor-control update per accepted go pulse:
//  integrator accumulate, I product, P product, then left and right motor sums.
//  Owns the ALU operand registers (Error, Intgrl, Icomp, Pcomp, Accum), drives the
//  ALU select/flag inputs and captures dst into the register the current step targets.
//  Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - pi_sequencer_if.master (handshake, ALU bus, operands, lft/rht)
//  Parameters:
//   INT_DEC_BITS - Intgrl is written only on every 2**INT_DEC_BITS-th update
//   MULT_CYCLES  - cycles each multiply step is held (>=1); dst captured on the last
//  Build option:
//   ANTI_WINDUP_EN - when defined, the Intgrl write is also skipped while the previous
//                    lft command sits at either saturation rail.
//
//  state  | meaning
//  IDLE   | waiting for go; ALU control word all zero
//  INTG   | Intgrl + (Error>>4), saturated; written only on decimation hit
//  ICOMP  | Iterm * Intgrl, held MULT_CYCLES -> Icomp
//  PCOMP  | Error * Pterm, held MULT_CYCLES -> Pcomp
//  L_ACC1 | Fwd - Pcomp -> Accum
//  L_ACC2 | Accum - Icomp, saturated -> lft
//  R_ACC1 | Fwd + Pcomp -> Accum
//  R_ACC2 | Accum + Icomp, saturated -> rht, pulse done
module pi_sequencer #(
    parameter int INT_DEC_BITS = 2,
    parameter int MULT_CYCLES  = 2
) (
    input  logic           clk,
    input  logic           rst,
    pi_sequencer_if.master bus
);
    localparam int IW = (INT_DEC_BITS > 0) ? INT_DEC_BITS : 1;
    localparam int MW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [MW-1:0] MLAST = MW'(MULT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INTG, ICOMP, PCOMP, L_ACC1, L_ACC2, R_ACC1, R_ACC2
    } state_t;

    typedef struct packed {
        logic [2:0] src1sel;
        logic [2:0] src0sel;
        logic       multiply;
        logic       mult2;
        logic       mult4;
        logic       sub;
        logic       saturate;
    } ctrl_t;

    // ALU control word belonging to each state; loaded together with the state so
    // the ALU sees a registered, glitch-free word for the whole step.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            INTG:    begin c.src1sel = 3'd3; c.src0sel = 3'd1; c.saturate = 1'b1; end
            ICOMP:   begin c.src1sel = 3'd1; c.src0sel = 3'd1; c.multiply = 1'b1; end
            PCOMP:   begin c.src1sel = 3'd2; c.src0sel = 3'd4; c.multiply = 1'b1; end
            L_ACC1:  begin c.src1sel = 3'd4; c.src0sel = 3'd3; c.sub = 1'b1; end
            L_ACC2:  begin
                c.src1sel = 3'd0; c.src0sel = 3'd2; c.sub = 1'b1; c.saturate = 1'b1;
            end
            R_ACC1:  begin c.src1sel = 3'd4; c.src0sel = 3'd3; end
            R_ACC2:  begin c.src1sel = 3'd0; c.src0sel = 3'd2; c.saturate = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t          state;
    ctrl_t           ctrl;
    logic            busy_r;
    logic            done_r;
    logic [MW-1:0]   mcnt;
    logic [IW-1:0]   int_dec;
    logic            intg_en;
    logic [11:0]     error_r;
    logic [11:0]     intgrl_r;
    logic [11:0]     icomp_r;
    logic [15:0]     pcomp_r;
    logic [15:0]     accum_r;
    logic [11:0]     lft_r;
    logic [11:0]     rht_r;
    logic            dec_hit;
    logic            windup_block;

    // With zero decimation bits every update writes the integrator.
    assign dec_hit = (INT_DEC_BITS == 0) || (int_dec == '1);

`ifdef ANTI_WINDUP_EN
    assign windup_block = (lft_r == 12'h7FF) || (lft_r == 12'h800);
`else
    assign windup_block = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ctrl     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            mcnt     <= '0;
            int_dec  <= '0;
            intg_en  <= 1'b0;
            error_r  <= '0;
            intgrl_r <= '0;
            icomp_r  <= '0;
            pcomp_r  <= '0;
            accum_r  <= '0;
            lft_r    <= '0;
            rht_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        error_r <= bus.err_in;
                        // Decimation decision uses the count before this increment.
                        intg_en <= dec_hit;
                        int_dec <= int_dec + 1'b1;
                        state   <= INTG;
                        ctrl    <= ctrl_of(INTG);
                        busy_r  <= 1'b1;
                    end
                end
                INTG: begin
                    if (intg_en && !windup_block) begin
                        intgrl_r <= bus.dst[11:0];
                    end
                    mcnt  <= '0;
                    state <= ICOMP;
                    ctrl  <= ctrl_of(ICOMP);
                end
                ICOMP: begin
                    if (mcnt == MLAST) begin
                        icomp_r <= bus.dst[11:0];
                        mcnt    <= '0;
                        state   <= PCOMP;
                        ctrl    <= ctrl_of(PCOMP);
                    end else begin
                        mcnt <= mcnt + 1'b1;
                    end
                end
                PCOMP: begin
                    if (mcnt == MLAST) begin
                        pcomp_r <= bus.dst;
                        mcnt    <= '0;
                        state   <= L_ACC1;
                        ctrl    <= ctrl_of(L_ACC1);
                    end else begin
                        mcnt <= mcnt + 1'b1;
                    end
                end
                L_ACC1: begin
                    accum_r <= bus.dst;
                    state   <= L_ACC2;
                    ctrl    <= ctrl_of(L_ACC2);
                end
                L_ACC2: begin
                    lft_r <= bus.dst[11:0];
                    state <= R_ACC1;
                    ctrl  <= ctrl_of(R_ACC1);
                end
                R_ACC1: begin
                    accum_r <= bus.dst;
                    state   <= R_ACC2;
                    ctrl    <= ctrl_of(R_ACC2);
                end
                R_ACC2: begin
                    rht_r  <= bus.dst[11:0];
                    done_r <= 1'b1;
                    state  <= IDLE;
                    ctrl   <= ctrl_of(IDLE);
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ctrl   <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.src1sel  = ctrl.src1sel;
    assign bus.src0sel  = ctrl.src0sel;
    assign bus.multiply = ctrl.multiply;
    assign bus.mult2    = ctrl.mult2;
    assign bus.mult4    = ctrl.mult4;
    assign bus.sub      = ctrl.sub;
    assign bus.saturate = ctrl.saturate;
    assign bus.Error    = error_r;
    assign bus.Intgrl   = intgrl_r;
    assign bus.Icomp    = icomp_r;
    assign bus.Pcomp    = pcomp_r;
    assign bus.Accum    = accum_r;
    assign bus.lft      = lft_r;
    assign bus.rht      = rht_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_pi_sequencer.sv
module tb_pi_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pi_sequencer_if bus();

    pi_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [11:0] lft;
        logic [11:0] rht;
        logic [11:0] intgrl;
    } exp_t;
    exp_t exp_q[$];

    // ALU stand-in: Iterm = Pterm = 16 with products scaled by 1/16, so each
    // multiply returns its data operand unchanged; saturate clamps to 12-bit signed.
    logic signed [17:0] a1, a0, ar;
    logic signed [35:0] aprod;
    always_comb begin
        a1 = '0;
        a0 = '0;
        aprod = '0;
        case (bus.src1sel)
            3'd0: a1 = {{2{bus.Accum[15]}}, bus.Accum};
            3'd1: a1 = 18'sd16;
            3'd2: a1 = {{6{bus.Error[11]}}, bus.Error};
            3'd3: a1 = {{10{bus.Error[11]}}, bus.Error[11:4]};
            3'd4: a1 = {6'd0, bus.Fwd};
            default: a1 = '0;
        endcase
        case (bus.src0sel)
            3'd1: a0 = {{6{bus.Intgrl[11]}}, bus.Intgrl};
            3'd2: a0 = {{6{bus.Icomp[11]}}, bus.Icomp};
            3'd3: a0 = {{2{bus.Pcomp[15]}}, bus.Pcomp};
            3'd4: a0 = 18'sd16;
            default: a0 = '0;
        endcase
        if (bus.multiply) begin
            aprod = a1 * a0;
            ar = aprod[21:4];
        end else if (bus.sub) begin
            ar = a1 - a0;
        end else begin
            ar = a1 + a0;
        end
        if (bus.saturate) begin
            if (ar > 18'sd2047) ar = 18'sd2047;
            else if (ar < -18'sd2048) ar = -18'sd2048;
        end
        bus.dst = ar[15:0];
    end

    logic [10:0] ctrl_word;
    assign ctrl_word = {bus.src1sel, bus.src0sel, bus.multiply, bus.mult2,
                        bus.mult4, bus.sub, bus.saturate};

    // Control word expected in the n-th busy cycle of an update (MULT_CYCLES = 2).
    function automatic logic [10:0] exp_ctrl(input int n);
        case (n)
            1:       return {3'd3, 3'd1, 5'b00001};
            2, 3:    return {3'd1, 3'd1, 5'b10000};
            4, 5:    return {3'd2, 3'd4, 5'b10000};
            6:       return {3'd4, 3'd3, 5'b00010};
            7:       return {3'd0, 3'd2, 5'b00011};
            8:       return {3'd4, 3'd3, 5'b00000};
            9:       return {3'd0, 3'd2, 5'b00001};
            default: return 11'h7FF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: checks the control word every cycle and pops one expected result per done.
    int idx = 0;
    always @(negedge clk) begin
        if (rst) begin
            idx = 0;
        end else begin
            if (bus.done) begin
                chk("latency", idx, 9);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 required no done");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("lft", bus.lft, e.lft);
                    chk("rht", bus.rht, e.rht);
                    chk("intgrl", bus.Intgrl, e.intgrl);
                end
            end
            if (bus.busy) begin
                idx++;
                chk("ctrl", ctrl_word, exp_ctrl(idx));
            end else begin
                idx = 0;
                chk("idle_ctrl", ctrl_word, 0);
            end
        end
    end

    task automatic do_rst();
        rst = 1'b1;
        bus.go = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue(input logic [11:0] e, input logic [11:0] f,
                         input logic [11:0] el, input logic [11:0] er, input logic [11:0] ei);
        @(negedge clk);
        bus.err_in = e;
        bus.Fwd    = f;
        bus.go     = 1'b1;
        exp_q.push_back('{el, er, ei});
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d pending updates required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [11:0] e, input logic [11:0] f,
                       input logic [11:0] el, input logic [11:0] er, input logic [11:0] ei);
        issue(e, f, el, er, ei);
        drain(40);
    endtask

    logic [11:0] aw_intgrl;

    initial begin
        bus.go = 1'b0;
        bus.err_in = '0;
        bus.Fwd = '0;
        rst = 1'b1;
        do_rst();

        chk("rst_lft", bus.lft, 0);
        chk("rst_rht", bus.rht, 0);
        chk("rst_error", bus.Error, 0);
        chk("rst_intgrl", bus.Intgrl, 0);
        chk("rst_icomp", bus.Icomp, 0);
        chk("rst_pcomp", bus.Pcomp, 0);
        chk("rst_accum", bus.Accum, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);

        // Zero error, forward only.
        run(12'h000, 12'h100, 12'h100, 12'h100, 12'h000);

        // Back-to-back: go held through the done cycle re-triggers.
        @(negedge clk);
        bus.go = 1'b1;
        exp_q.push_back('{12'h100, 12'h100, 12'h000});
        exp_q.push_back('{12'h100, 12'h100, 12'h000});
        repeat (11) @(negedge clk);
        bus.go = 1'b0;
        drain(40);

        // Integrator decimation: only the 4th update writes Intgrl.
        do_rst();
        run(12'h100, 12'h100, 12'h000, 12'h200, 12'h000);
        run(12'h100, 12'h100, 12'h000, 12'h200, 12'h000);
        run(12'h100, 12'h100, 12'h000, 12'h200, 12'h000);
        run(12'h100, 12'h100, 12'hFF0, 12'h210, 12'h010);

        // Saturation at both rails.
        do_rst();
        run(12'h7FF, 12'h7FF, 12'h000, 12'h7FF, 12'h000);
        run(12'h800, 12'h000, 12'h7FF, 12'h800, 12'h000);

        // Anti-windup: lft pinned at the positive rail when the 4th update arrives.
`ifdef ANTI_WINDUP_EN
        aw_intgrl = 12'h000;
`else
        aw_intgrl = 12'hF80;
`endif
        do_rst();
        run(12'h800, 12'h000, 12'h7FF, 12'h800, 12'h000);
        run(12'h800, 12'h000, 12'h7FF, 12'h800, 12'h000);
        run(12'h800, 12'h000, 12'h7FF, 12'h800, 12'h000);
        run(12'h800, 12'h000, 12'h7FF, 12'h800, aw_intgrl);

        // go pulsed mid-sequence is dropped; a queued retrigger would show as an extra done.
        do_rst();
        issue(12'h000, 12'h100, 12'h100, 12'h100, 12'h000);
        repeat (3) @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        drain(40);
        repeat (15) @(negedge clk);

        // Reset in cycle 5 aborts the update with no done.
        @(negedge clk);
        bus.err_in = 12'h100;
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_lft", bus.lft, 0);
        chk("abort_rht", bus.rht, 0);
        chk("abort_error", bus.Error, 0);
        chk("abort_pcomp", bus.Pcomp, 0);
        chk("abort_ctrl", ctrl_word, 0);
        repeat (20) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "global timeout");
    end
endmodule
